// File: rtl/uart_apb_sequencer.sv
// APB master that configures one CoreUARTapb and then services TX/RX bytes by status polling.
// Optional per-error RX counters are enabled with `define UART_SEQ_ERR_CNT_EN.
module uart_apb_sequencer #(
    parameter int POLL_GAP = 4,
    parameter bit CFG_AUTO = 1'b0
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        cfg_start,
    input  logic [12:0] cfg_baud,
    input  logic        cfg_bit8,
    input  logic        cfg_parity_en,
    input  logic        cfg_parity_odd,
    output logic        cfg_done,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [2:0]  rx_err,
    output logic [4:0]  PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PWDATA,
    input  logic [7:0]  PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    output logic        apb_err
`ifdef UART_SEQ_ERR_CNT_EN
    ,
    output logic [7:0]  err_parity_cnt,
    output logic [7:0]  err_frame_cnt,
    output logic [7:0]  err_ovf_cnt
`endif
);

    localparam logic [2:0] ST_UNCFG = 3'd0, ST_CFG1 = 3'd1, ST_CFG2 = 3'd2, ST_GAP = 3'd3,
                           ST_POLL  = 3'd4, ST_TXWR = 3'd5, ST_RXRD = 3'd6;
    localparam logic [4:0] A_TXDATA = 5'h00, A_RXDATA = 5'h04, A_CTRL1 = 5'h08,
                           A_CTRL2  = 5'h0C, A_STATUS = 5'h10;

    logic [2:0]  state_q, state_d;
    logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [4:0]  paddr_q, paddr_d;
    logic [7:0]  pwdata_q, pwdata_d;
    logic [7:0]  gap_q, gap_d;
    logic        last_grant_q, last_grant_d;      // 1 = TX granted last
    logic [12:0] baud_q, baud_n;
    logic [2:0]  ctrl_q, ctrl_n;                   // {parity_odd, parity_en, bit8}
    logic [7:0]  hold_q, rx_data_q;
    logic        hold_full_q, rx_valid_q, cfg_done_q, cfg_pend_q, apb_err_q;
    logic [2:0]  err_q, rx_err_q;                  // {FRAMING, OVERFLOW, PARITY}
    logic        start, xfer_done, configured, cfg_req, cfg_take, rx_elig, tx_elig;

    assign xfer_done  = psel_q & penable_q & PREADY;
    assign configured = state_q inside {ST_GAP, ST_POLL, ST_TXWR, ST_RXRD};
    assign cfg_req    = configured & (cfg_start | cfg_pend_q);
    assign cfg_take   = ((state_q == ST_UNCFG) & (cfg_start | CFG_AUTO)) | (configured & cfg_start);
    assign baud_n     = cfg_take ? cfg_baud : baud_q;
    assign ctrl_n     = cfg_take ? {cfg_parity_odd, cfg_parity_en, cfg_bit8} : ctrl_q;
    // A status read that ends in PSLVERR is discarded, so it grants nothing.
    assign rx_elig    = PRDATA[1] & ~rx_valid_q & ~PSLVERR;
    assign tx_elig    = PRDATA[0] & hold_full_q & ~PSLVERR;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        gap_d        = gap_q;
        last_grant_d = last_grant_q;
        start        = 1'b0;
        case (state_q)
            ST_UNCFG: if (cfg_start || CFG_AUTO) begin
                state_d = ST_CFG1;
                start   = 1'b1;
            end
            ST_GAP: begin
                if (cfg_req) begin
                    state_d = ST_CFG1;
                    start   = 1'b1;
                end else if ({1'b0, gap_q} + 9'd1 >= 9'(POLL_GAP)) begin
                    state_d = ST_POLL;
                    start   = 1'b1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            ST_CFG1, ST_CFG2, ST_POLL, ST_TXWR, ST_RXRD: begin
                if (!psel_q) begin
                    // Idle cycle after a completed transfer; launch the pending one now.
                    if (cfg_req) state_d = ST_CFG1;
                    start = 1'b1;
                end else if (!penable_q) begin
                    penable_d = 1'b1;
                end else if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    gap_d     = 8'd0;
                    state_d   = ST_GAP;
                    if (state_q == ST_CFG1) state_d = ST_CFG2;
                    if (state_q == ST_POLL && !cfg_req) begin
                        if (rx_elig && tx_elig) begin
                            state_d      = last_grant_q ? ST_RXRD : ST_TXWR;
                            last_grant_d = ~last_grant_q;
                        end else if (tx_elig) begin
                            state_d      = ST_TXWR;
                            last_grant_d = 1'b1;
                        end else if (rx_elig) begin
                            state_d      = ST_RXRD;
                            last_grant_d = 1'b0;
                        end
                    end
                    if (cfg_req) state_d = ST_CFG1;
                end
            end
            default: state_d = ST_UNCFG;
        endcase
        if (start) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
        end
    end

    always_comb begin
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        if (start) begin
            pwrite_d = 1'b0;
            pwdata_d = 8'h00;
            case (state_d)
                ST_CFG1: begin paddr_d = A_CTRL1;  pwrite_d = 1'b1; pwdata_d = baud_n[7:0]; end
                ST_CFG2: begin paddr_d = A_CTRL2;  pwrite_d = 1'b1; pwdata_d = {baud_n[12:8], ctrl_n}; end
                ST_TXWR: begin paddr_d = A_TXDATA; pwrite_d = 1'b1; pwdata_d = hold_q; end
                ST_RXRD: paddr_d = A_RXDATA;
                default: paddr_d = A_STATUS;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q      <= ST_UNCFG;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            paddr_q      <= 5'h00;
            pwrite_q     <= 1'b0;
            pwdata_q     <= 8'h00;
            gap_q        <= 8'h00;
            last_grant_q <= 1'b0;
            baud_q       <= 13'h0000;
            ctrl_q       <= 3'b000;
            hold_q       <= 8'h00;
            hold_full_q  <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            rx_err_q     <= 3'b000;
            err_q        <= 3'b000;
            cfg_done_q   <= 1'b0;
            cfg_pend_q   <= 1'b0;
            apb_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            gap_q        <= gap_d;
            last_grant_q <= last_grant_d;
            if (cfg_take) begin
                baud_q <= cfg_baud;
                ctrl_q <= {cfg_parity_odd, cfg_parity_en, cfg_bit8};
            end
            if (state_q == ST_TXWR && xfer_done) begin
                hold_full_q <= 1'b0;
            end else if (tx_valid && !hold_full_q) begin
                hold_full_q <= 1'b1;
                hold_q      <= tx_data;
            end
            if (state_q == ST_POLL && xfer_done) err_q <= PSLVERR ? 3'b000 : PRDATA[4:2];
            if (state_q == ST_RXRD && xfer_done && !PSLVERR) begin
                rx_data_q  <= PRDATA;
                rx_err_q   <= err_q;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (cfg_take)                             cfg_done_q <= 1'b0;
            else if (state_q == ST_CFG2 && xfer_done) cfg_done_q <= 1'b1;
            if (state_d == ST_CFG1)            cfg_pend_q <= 1'b0;
            else if (configured && cfg_start)  cfg_pend_q <= 1'b1;
            if (xfer_done && PSLVERR) apb_err_q <= 1'b1;
            else if (cfg_start)       apb_err_q <= 1'b0;
        end
    end

`ifdef UART_SEQ_ERR_CNT_EN
    logic [7:0] par_cnt_q, frm_cnt_q, ovf_cnt_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            par_cnt_q <= 8'h00;
            frm_cnt_q <= 8'h00;
            ovf_cnt_q <= 8'h00;
        end else if (cfg_start) begin
            par_cnt_q <= 8'h00;
            frm_cnt_q <= 8'h00;
            ovf_cnt_q <= 8'h00;
        end else if (state_q == ST_RXRD && xfer_done) begin
            if (err_q[0] && par_cnt_q != 8'hFF) par_cnt_q <= par_cnt_q + 8'd1;
            if (err_q[1] && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
            if (err_q[2] && frm_cnt_q != 8'hFF) frm_cnt_q <= frm_cnt_q + 8'd1;
        end
    end

    assign err_parity_cnt = par_cnt_q;
    assign err_frame_cnt  = frm_cnt_q;
    assign err_ovf_cnt    = ovf_cnt_q;
`endif

    assign PSEL     = psel_q;
    assign PENABLE  = penable_q;
    assign PADDR    = paddr_q;
    assign PWRITE   = pwrite_q;
    assign PWDATA   = pwdata_q;
    assign cfg_done = cfg_done_q;
    assign tx_ready = ~hold_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign apb_err  = apb_err_q;

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: APB slave model, transfer log and protocol monitor.
module tb_uart_apb_sequencer;

    logic        PCLK, PRESETN;
    logic        cfg_start, cfg_bit8, cfg_parity_en, cfg_parity_odd, cfg_done;
    logic [12:0] cfg_baud;
    logic [7:0]  tx_data, rx_data, PWDATA, PRDATA;
    logic        tx_valid, tx_ready, rx_valid, rx_ready;
    logic [2:0]  rx_err;
    logic [4:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR, apb_err;
`ifdef UART_SEQ_ERR_CNT_EN
    logic [7:0]  err_parity_cnt, err_frame_cnt, err_ovf_cnt;
`endif

    uart_apb_sequencer dut (
        .PCLK(PCLK), .PRESETN(PRESETN),
        .cfg_start(cfg_start), .cfg_baud(cfg_baud), .cfg_bit8(cfg_bit8),
        .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd), .cfg_done(cfg_done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_err(rx_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .apb_err(apb_err)
`ifdef UART_SEQ_ERR_CNT_EN
        , .err_parity_cnt(err_parity_cnt), .err_frame_cnt(err_frame_cnt), .err_ovf_cnt(err_ovf_cnt)
`endif
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model: STATUS/RXDATA from bench variables; wait states and PSLVERR only on TXDATA writes.
    logic [7:0] status_v, rxdata_v;
    int         wait_tx, acc_cnt;
    logic       slverr_on;
    wire        tx_access = PSEL && PENABLE && PWRITE && (PADDR == 5'h00);

    assign PRDATA  = (PADDR == 5'h10) ? status_v : (PADDR == 5'h04) ? rxdata_v : 8'h00;
    assign PREADY  = acc_cnt >= (tx_access ? wait_tx : 0);
    assign PSLVERR = slverr_on && tx_access;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    // Transfer log of non-STATUS transfers: {write, addr, data, access cycles}.
    typedef struct packed {
        logic       w;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] len;
    } xfer_t;
    xfer_t      xq[$];
    int         poll_cnt, acc_run, stab_err, proto_err;
    logic [4:0] s_addr;
    logic [7:0] s_wdata;
    logic       s_write, prev_done, prev_setup;

    always @(posedge PCLK) begin
        if (PSEL && PENABLE) begin
            if (PADDR !== s_addr || PWDATA !== s_wdata || PWRITE !== s_write) stab_err <= stab_err + 1;
            if (PREADY) begin
                if (PADDR == 5'h10) poll_cnt <= poll_cnt + 1;
                else xq.push_back({PWRITE, PADDR, (PWRITE ? PWDATA : PRDATA), 8'(acc_run + 1)});
                acc_run <= 0;
            end else begin
                acc_run <= acc_run + 1;
            end
        end
        if (PSEL && !PENABLE) begin
            s_addr  <= PADDR;
            s_wdata <= PWDATA;
            s_write <= PWRITE;
        end
        if (PRESETN) begin
            if (prev_done && PSEL)                 proto_err <= proto_err + 1;
            if (PENABLE && !PSEL)                  proto_err <= proto_err + 1;
            if (prev_setup && !(PSEL && PENABLE))  proto_err <= proto_err + 1;
        end
        prev_done  <= PSEL && PENABLE && PREADY;
        prev_setup <= PSEL && !PENABLE;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge PCLK);
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge PCLK);
        tx_valid = 1'b0;
    endtask

    task automatic pulse_cfg(input logic [12:0] baud, input logic b8, input logic pen, input logic podd);
        cfg_baud = baud; cfg_bit8 = b8; cfg_parity_en = pen; cfg_parity_odd = podd;
        cfg_start = 1'b1;
        @(negedge PCLK);
        cfg_start = 1'b0;
        // Scramble the inputs to prove the sequencer uses the values captured at cfg_start.
        cfg_baud = 13'h1FFF; cfg_bit8 = ~b8; cfg_parity_en = ~pen; cfg_parity_odd = ~podd;
    endtask

    int  polls_snap, rd_cnt;
    bit  bad;

    initial begin
        PRESETN = 1'b0; cfg_start = 1'b0; cfg_baud = '0; cfg_bit8 = 1'b0;
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        rx_ready = 1'b0; status_v = 8'h00; rxdata_v = 8'h00; wait_tx = 0; slverr_on = 1'b0;
        cycles(2);

        // Reset values
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_paddr", PADDR, 5'h00);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_pwdata", PWDATA, 8'h00);
        check("rst_cfg_done", cfg_done, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_err", rx_err, 3'b000);
        check("rst_apb_err", apb_err, 1'b0);
        PRESETN = 1'b1;
        cycles(5);
        check("uncfg_idle_psel", PSEL, 1'b0);

        // Configuration: CTRL1 = 0xA5, CTRL2 = {00001,0,1,1} = 0x0B
        xq.delete();
        pulse_cfg(13'h1A5, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 100 && !cfg_done; n++) @(negedge PCLK);
        check("cfg_done_rise", cfg_done, 1'b1);
        check("cfg_nwrites_at_done", xq.size(), 2);
        check("cfg_w1", {xq[0].w, xq[0].a, xq[0].d}, {1'b1, 5'h08, 8'hA5});
        check("cfg_w2", {xq[1].w, xq[1].a, xq[1].d}, {1'b1, 5'h0C, 8'h0B});

        // TX: one write of 0x5A; tx_ready low until it completes
        xq.delete();
        status_v = 8'h01;
        push_tx(8'h5A);
        check("tx_ready_after_accept", tx_ready, 1'b0);
        bad = 1'b0;
        for (int n = 0; n < 100 && xq.size() == 0; n++) begin
            if (tx_ready !== 1'b0) bad = 1'b1;
            @(negedge PCLK);
        end
        check("tx_ready_low_during", bad, 1'b0);
        check("tx_write", {xq[0].w, xq[0].a, xq[0].d}, {1'b1, 5'h00, 8'h5A});
        check("tx_ready_after_write", tx_ready, 1'b1);
        cycles(40);
        check("tx_single_write", xq.size(), 1);
        status_v = 8'h00;

        // RX with back-pressure
        xq.delete();
        rxdata_v = 8'hC3;
        status_v = 8'h02;
        for (int n = 0; n < 100 && !rx_valid; n++) @(negedge PCLK);
        check("rx1_valid", rx_valid, 1'b1);
        check("rx1_data", rx_data, 8'hC3);
        check("rx1_err", rx_err, 3'b000);
        polls_snap = poll_cnt;
        rxdata_v = 8'h3C;
        cycles(60);
        check("rx_bp_polls_continue", poll_cnt > polls_snap + 3, 1'b1);
        check("rx_bp_single_read", xq.size(), 1);
        check("rx_bp_valid_held", rx_valid, 1'b1);
        check("rx_bp_data_held", rx_data, 8'hC3);
        rx_ready = 1'b1;
        @(negedge PCLK);
        rx_ready = 1'b0;
        check("rx_accept_clears", rx_valid, 1'b0);
        for (int n = 0; n < 100 && !rx_valid; n++) @(negedge PCLK);
        check("rx2_data", rx_data, 8'h3C);
        status_v = 8'h00;
        rx_ready = 1'b1;
        cycles(2);

        // Arbitration: last grant was RX, so TX goes first then alternates
        tx_data = 8'h11;
        tx_valid = 1'b1;
        cycles(2);
        xq.delete();
        rxdata_v = 8'h77;
        status_v = 8'h03;
        for (int n = 0; n < 300 && xq.size() < 4; n++) @(negedge PCLK);
        status_v = 8'h00;
        tx_valid = 1'b0;
        check("arb_count", xq.size() >= 4, 1'b1);
        check("arb_g0_tx", {xq[0].a, xq[0].d}, {5'h00, 8'h11});
        check("arb_g1_rx", {xq[1].w, xq[1].a}, {1'b0, 5'h04});
        check("arb_g2_tx", xq[2].a, 5'h00);
        check("arb_g3_rx", xq[3].a, 5'h04);
        cycles(2);
        status_v = 8'h01;
        for (int n = 0; n < 100 && !tx_ready; n++) @(negedge PCLK);
        status_v = 8'h00;
        rx_ready = 1'b0;
        cycles(15);

        // Wait states on TX write: 3 PREADY-low access cycles
        xq.delete();
        wait_tx = 3;
        push_tx(8'hE7);
        status_v = 8'h01;
        for (int n = 0; n < 100 && xq.size() == 0; n++) @(negedge PCLK);
        status_v = 8'h00;
        wait_tx = 0;
        check("ws_write", {xq[0].w, xq[0].a, xq[0].d}, {1'b1, 5'h00, 8'hE7});
        check("ws_access_len", xq[0].len, 8'd4);
        check("apb_stable", stab_err, 0);
        check("apb_protocol", proto_err, 0);

        // PSLVERR: byte consumed, apb_err sticky until cfg_start
        xq.delete();
        slverr_on = 1'b1;
        push_tx(8'h99);
        status_v = 8'h01;
        for (int n = 0; n < 100 && !tx_ready; n++) @(negedge PCLK);
        status_v = 8'h00;
        slverr_on = 1'b0;
        check("slverr_consumed", tx_ready, 1'b1);
        check("slverr_apb_err", apb_err, 1'b1);
        cycles(10);
        check("apb_err_sticky", apb_err, 1'b1);

        // Reconfigure with a held TX byte: CTRL1 = 0x0F, CTRL2 = {11111,1,1,0} = 0xFE
        push_tx(8'h42);
        xq.delete();
        pulse_cfg(13'h1F0F, 1'b0, 1'b1, 1'b1);
        check("recfg_done_drop", cfg_done, 1'b0);
        check("recfg_apb_err_clr", apb_err, 1'b0);
        for (int n = 0; n < 100 && !cfg_done; n++) @(negedge PCLK);
        check("recfg_done", cfg_done, 1'b1);
        check("recfg_w1", {xq[0].w, xq[0].a, xq[0].d}, {1'b1, 5'h08, 8'h0F});
        check("recfg_w2", {xq[1].w, xq[1].a, xq[1].d}, {1'b1, 5'h0C, 8'hFE});
        check("recfg_hold_kept", tx_ready, 1'b0);
        status_v = 8'h01;
        for (int n = 0; n < 100 && !tx_ready; n++) @(negedge PCLK);
        status_v = 8'h00;
        check("recfg_hold_flush", {xq[2].a, xq[2].d}, {5'h00, 8'h42});

        // Error bits: STATUS 0x16 -> {FE,OVF,PE} = 3'b101
        xq.delete();
        rxdata_v = 8'h00;
        status_v = 8'h16;
        for (int n = 0; n < 100 && !rx_valid; n++) @(negedge PCLK);
        status_v = 8'h00;
        check("err_rx_valid", rx_valid, 1'b1);
        check("err_rx_err", rx_err, 3'b101);
        check("err_rx_data", rx_data, 8'h00);
`ifdef UART_SEQ_ERR_CNT_EN
        check("cnt_parity", err_parity_cnt, 8'd1);
        check("cnt_frame", err_frame_cnt, 8'd1);
        check("cnt_ovf", err_ovf_cnt, 8'd0);
`endif
        rx_ready = 1'b1;
        @(negedge PCLK);
        rx_ready = 1'b0;
        cycles(10);
        check("apb_protocol_end", proto_err, 0);
        check("apb_stable_end", stab_err, 0);

        // Asynchronous reset in the middle of a stalled TX write
        xq.delete();
        wait_tx = 10;
        push_tx(8'h33);
        status_v = 8'h01;
        for (int n = 0; n < 100 && !(PSEL && PENABLE && PWRITE && PADDR == 5'h00); n++) @(negedge PCLK);
        check("arst_in_access", PSEL && PENABLE && PWRITE, 1'b1);
        @(negedge PCLK);
        #2 PRESETN = 1'b0;
        #1;
        check("arst_psel_drop", PSEL, 1'b0);
        check("arst_penable_drop", PENABLE, 1'b0);
        check("arst_tx_ready", tx_ready, 1'b1);
        @(negedge PCLK);
        PRESETN = 1'b1;
        bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (PSEL !== 1'b0) bad = 1'b1;
            @(negedge PCLK);
        end
        check("arst_no_retry", bad, 1'b0);
        check("arst_no_completion", xq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
